load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface in the multicycle CPU. Accepts one load/store request at a time from the execute stage and drives the active-low RD/WR strobes, word address and write data of the byte-addressed, big-endian data memory. Supports byte, halfword and word accesses. Sub-word stores are done as read-modify-write. Misaligned or illegal requests are flagged and never reach memory.

## Interface
- WAIT_CYCLES, 1: cycles RD is held low before read data is captured; legal range 1..15.
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend sub-word loads; ignored for stores and words.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned address or size 11.
- RD  out  1  memory read strobe, active-low.
- WR  out  1  memory write strobe, active-low.
- DAddr  out  32  memory address, always {addr[31:2],2'b00}.
- DataIn  out  32  word written to memory.
- DataOut  in  32  word read from memory.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1. req_ready=1 only in IDLE. All request fields are latched at acceptance.
- Alignment check at acceptance:
  - Half requires addr[0]=0. Word requires addr[1:0]=00. Size 11 is always illegal.
  - On failure: IDLE→RESP with resp_err=1, no strobe asserted.
- Lane map (big-endian):
  - Byte lane k=addr[1:0] occupies bits [31-8k : 24-8k].
  - Half at addr[1]=0 occupies [31:16]; at addr[1]=1 it occupies [15:0].
- Transitions:
  - Load: IDLE→READ→RESP.
  - Word store: IDLE→WRITE→RESP.
  - Byte/half store: IDLE→READ→WRITE→RESP.
- READ:
  - RD=0, WR=1 for WAIT_CYCLES cycles, counted by a 4-bit counter.
  - DataOut is captured on the edge ending the last READ cycle.
  - Load result is the extracted lane, zero- or sign-extended to 32 bits.
  - For a sub-word store, the captured word has the target lane replaced by req_wdata's low bits to form the merged word.
- WRITE:
  - WR=0, RD=1 for exactly one cycle.
  - DataIn = merged word, or req_wdata for a word store.
  - DAddr and DataIn are registered and stable the whole cycle.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no response back-pressure.
- RD and WR are never low in the same cycle. Both are high in IDLE and RESP.
- DAddr and DataIn hold their last values in IDLE.

## Timing
- Reset values: RD=1, WR=1, DAddr=0, DataIn=0, req_ready=0 while Reset=1, resp_valid=0, resp_rdata=0, resp_err=0, state IDLE, counter 0.
- req_ready=1 from the first cycle after Reset deasserts.
- Latency, from accept edge to the cycle resp_valid=1, with W = WAIT_CYCLES:
  - Load: W+1 cycles.
  - Word store: 2 cycles.
  - Sub-word store: W+2 cycles.
  - Error: 1 cycle.
- Back-to-back: the earliest next acceptance is the edge ending RESP+IDLE, i.e. one idle cycle between requests.
- Reset mid-operation:
  - The next edge forces all reset values and RD=WR=1.
  - An in-flight request is dropped with no resp_valid.
  - A WRITE cycle interrupted by Reset may already have updated memory; this is permitted.
- resp_rdata and resp_err hold their values after the pulse until the next response.

## Test plan
- Word store then load, W=1: store 0xDEADBEEF at 0x10, then load word 0x10. Required: WR low 1 cycle with DAddr=0x10 and DataIn=0xDEADBEEF; load resp_rdata=0xDEADBEEF at 2 cycles after accept.
- Sub-word loads: memory 0x20 = 0x80FF7F01.
  - Signed byte at 0x20 → 0xFFFFFF80; unsigned byte at 0x21 → 0x000000FF.
  - Signed half at 0x22 → 0x00007F01; signed half at 0x20 → 0xFFFF80FF.
- Byte store RMW, W=3: memory 0x30 = 0x11223344; store byte 0xAA at 0x32. Required: RD low 3 cycles, then WR low 1 cycle with DataIn=0x1122AA44; resp_valid at cycle 5.
- Errors: half load at 0x21, word store at 0x42, size 11 at 0x40. Each gives resp_err=1 one cycle after accept, RD/WR never low, memory unchanged.
- Reset during READ (W=4, reset on 2nd READ cycle): next cycle RD=1, no resp_valid; a subsequent word load succeeds normally.
- Strobe checker over 1000 random requests against the bench memory model:
  - RD and WR never simultaneously low.
  - Results match the reference model.
  - req_ready is never high outside IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the multicycle CPU's data-memory interface. It accepts
//   one load/store at a time from the execute stage and drives the active-low
//   RD/WR strobes, word address and write data of a byte-addressed,
//   big-endian memory. Sub-word stores are done as read-modify-write.
//   Misaligned or illegal requests are answered with resp_err and never
//   reach memory.
//
// Parameters
//   WAIT_CYCLES  cycles RD is held low before DataOut is captured (1..15)
//
// Ports
//   CLK, Reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            sign-extend sub-word loads
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  load result / error flag, held until next response
//   RD, WR                active-low memory strobes
//   DAddr, DataIn         registered word address and write data
//   DataOut               word read from memory
module load_store_unit #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        RD,
  output logic        WR,
  output logic [31:0] DAddr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept;
  logic        req_ok;
  logic        read_done;

  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // Alignment rule: halves on even addresses, words on multiples of four.
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lane[0];
      SZ_WORD: ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Big-endian lane extraction: byte lane k sits at [31-8k:24-8k],
  // the half at lane[1]=0 sits in the upper 16 bits.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane,
                                          input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the target lane of the word just read with the store data.
  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [1:0]  size,
                                        input logic [1:0]  lane,
                                        input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    r[31:24] = wdata[7:0];
        2'd1:    r[23:16] = wdata[7:0];
        2'd2:    r[15:8]  = wdata[7:0];
        default: r[7:0]   = wdata[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (lane[1]) r[15:0]  = wdata[15:0];
      else         r[31:16] = wdata[15:0];
    end else begin
      r = wdata;
    end
    return r;
  endfunction

  assign accept    = req_valid && (state == IDLE);
  assign req_ok    = aligned(req_size, req_addr[1:0]);
  assign read_done = (state == READ) && (cnt == LAST_CNT);

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    RD         = 1'b1;
    WR         = 1'b1;
    case (state)
      IDLE: begin
        req_ready = ~Reset;
        if (accept) begin
          if (!req_ok)                           state_nxt = RESP;
          else if (req_we && req_size == SZ_WORD) state_nxt = WRITE;
          else                                   state_nxt = READ;
        end
      end
      READ: begin
        RD = 1'b0;
        if (read_done) state_nxt = we_q ? WRITE : RESP;
      end
      WRITE: begin
        WR        = 1'b0;
        state_nxt = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
    endcase
  end

  // Request fields are captured once at acceptance and used by later states.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q     <= req_we;
      size_q   <= req_size;
      signed_q <= req_signed;
      lane_q   <= req_addr[1:0];
      wdata_q  <= req_wdata;
    end
  end

  // Wait counter, memory-side registers and held response fields.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt        <= 4'd0;
      DAddr      <= 32'd0;
      DataIn     <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (accept) begin
            if (!req_ok) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              DAddr <= {req_addr[31:2], 2'b00};
              if (req_we && req_size == SZ_WORD) DataIn <= req_wdata;
            end
          end
        end
        READ: begin
          if (cnt == LAST_CNT) begin
            cnt <= 4'd0;
            if (we_q) begin
              DataIn <= merge(DataOut, size_q, lane_q, wdata_q);
            end else begin
              resp_rdata <= extract(DataOut, size_q, lane_q, signed_q);
              resp_err   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WRITE: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int N = 3;

  logic           CLK = 1'b0;
  logic [N-1:0]   Reset, req_valid, req_ready, req_we, req_signed;
  logic [N-1:0]   resp_valid, resp_err, RD, WR;
  logic [1:0]     req_size   [N];
  logic [31:0]    req_addr   [N];
  logic [31:0]    req_wdata  [N];
  logic [31:0]    resp_rdata [N];
  logic [31:0]    DAddr      [N];
  logic [31:0]    DataIn     [N];
  logic [31:0]    DataOut    [N];
  logic [31:0]    mem        [N][256];
  logic [31:0]    ref_mem    [16];

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int ready_bad = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    load_store_unit #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
      .CLK       (CLK),
      .Reset     (Reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_size  (req_size[g]),
      .req_signed(req_signed[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .RD        (RD[g]),
      .WR        (WR[g]),
      .DAddr     (DAddr[g]),
      .DataIn    (DataIn[g]),
      .DataOut   (DataOut[g])
    );
    assign DataOut[g] = mem[g][DAddr[g][9:2]];
  end

  always @(posedge CLK)
    for (int i = 0; i < N; i++)
      if (!WR[i]) mem[i][DAddr[i][9:2]] <= DataIn[i];

  always @(negedge CLK)
    for (int k = 0; k < N; k++) begin
      if (!RD[k] && !WR[k]) overlap++;
      if (req_ready[k] && (!RD[k] || !WR[k] || resp_valid[k])) ready_bad++;
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  // Independent big-endian reference: shift/mask arithmetic.
  function automatic int lane_shift(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 24 - 8 * int'(off);
    if (sz == 2'd1) return 16 - 8 * int'(off);
    return 0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] sz);
    if (sz == 2'd0) return 32'h0000_00FF;
    if (sz == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] off);
    logic [31:0] m, v;
    m = lane_mask(sz);
    v = (w >> lane_shift(sz, off)) & m;
    if (sg && sz == 2'd0 && v[7])  v = v | ~m;
    if (sg && sz == 2'd1 && v[15]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    m  = lane_mask(sz);
    sh = lane_shift(sz, off);
    return (w & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  task automatic xact(input int i, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output int rdc, output int wrc,
                      output logic [31:0] waddr, output logic [31:0] wdat);
    int n;
    rdata = 32'd0; err = 1'b0; lat = 99; rdc = 0; wrc = 0; waddr = 32'd0; wdat = 32'd0;
    n = 0;
    @(negedge CLK);
    while (!req_ready[i] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready[i]) begin
      check("ready_timeout", {31'd0, req_ready[i]}, 32'd1);
      return;
    end
    req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = sz; req_signed[i] = sg;
    req_addr[i] = a; req_wdata[i] = wd;
    @(posedge CLK);
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c == 1) req_valid[i] = 1'b0;
      if (!RD[i]) rdc++;
      if (!WR[i]) begin
        wrc++;
        waddr = DAddr[i];
        wdat  = DataIn[i];
      end
      if (resp_valid[i]) begin
        lat   = c;
        rdata = resp_rdata[i];
        err   = resp_err[i];
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd, wa, wdt, a, wd, er;
    logic        e, we, sg, ee;
    logic [1:0]  sz;
    int          lat, rdc, wrc, vcnt, w;

    Reset = '1; req_valid = '0; req_we = '0; req_signed = '0;
    for (int i = 0; i < N; i++) begin
      req_size[i] = 2'd0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      check("rst_RD", RD[i], 1); check("rst_WR", WR[i], 1);
      check("rst_DAddr", DAddr[i], 0); check("rst_DataIn", DataIn[i], 0);
      check("rst_ready", req_ready[i], 0); check("rst_resp_valid", resp_valid[i], 0);
      check("rst_rdata", resp_rdata[i], 0); check("rst_err", resp_err[i], 0);
    end
    Reset = '0;
    @(negedge CLK);
    for (int i = 0; i < N; i++) check("ready_after_rst", req_ready[i], 1);

    // Word store then load, W=1
    xact(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, e, lat, rdc, wrc, wa, wdt);
    check("wst_wr_cycles", wrc, 1); check("wst_rd_cycles", rdc, 0);
    check("wst_daddr", wa, 32'h10); check("wst_datain", wdt, 32'hDEADBEEF);
    check("wst_lat", lat, 2); check("wst_err", e, 0);
    xact(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, e, lat, rdc, wrc, wa, wdt);
    check("wld_rdata", rd, 32'hDEADBEEF); check("wld_lat", lat, 2); check("wld_rd_cycles", rdc, 1);

    // Sub-word loads
    xact(0, 1, 2'd2, 0, 32'h20, 32'h80FF7F01, rd, e, lat, rdc, wrc, wa, wdt);
    xact(0, 0, 2'd0, 1, 32'h20, 32'h0, rd, e, lat, rdc, wrc, wa, wdt);
    check("lb_s_20", rd, 32'hFFFFFF80); check("lb_lat", lat, 2);
    xact(0, 0, 2'd0, 0, 32'h21, 32'h0, rd, e, lat, rdc, wrc, wa, wdt);
    check("lb_u_21", rd, 32'h000000FF);
    xact(0, 0, 2'd1, 1, 32'h22, 32'h0, rd, e, lat, rdc, wrc, wa, wdt);
    check("lh_s_22", rd, 32'h00007F01);
    xact(0, 0, 2'd1, 1, 32'h20, 32'h0, rd, e, lat, rdc, wrc, wa, wdt);
    check("lh_s_20", rd, 32'hFFFF80FF);

    // Byte store read-modify-write, W=3
    xact(1, 1, 2'd2, 0, 32'h30, 32'h11223344, rd, e, lat, rdc, wrc, wa, wdt);
    xact(1, 1, 2'd0, 0, 32'h32, 32'h555555AA, rd, e, lat, rdc, wrc, wa, wdt);
    check("sb_rd_cycles", rdc, 3); check("sb_wr_cycles", wrc, 1);
    check("sb_datain", wdt, 32'h1122AA44); check("sb_daddr", wa, 32'h30);
    check("sb_lat", lat, 5); check("sb_mem", mem[1][12], 32'h1122AA44);

    // Errors
    xact(1, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, rd, e, lat, rdc, wrc, wa, wdt);
    xact(1, 0, 2'd1, 0, 32'h21, 32'h0, rd, e, lat, rdc, wrc, wa, wdt);
    check("err_lh21_err", e, 1); check("err_lh21_lat", lat, 1);
    check("err_lh21_rd", rdc, 0); check("err_lh21_rdata", rd, 0);
    @(negedge CLK);
    check("err_hold", resp_err[1], 1); check("err_pulse_end", resp_valid[1], 0);
    xact(1, 1, 2'd2, 0, 32'h42, 32'h12345678, rd, e, lat, rdc, wrc, wa, wdt);
    check("err_sw42_err", e, 1); check("err_sw42_lat", lat, 1); check("err_sw42_wr", wrc, 0);
    xact(1, 1, 2'd3, 0, 32'h40, 32'h87654321, rd, e, lat, rdc, wrc, wa, wdt);
    check("err_sz3_err", e, 1); check("err_sz3_lat", lat, 1);
    check("err_sz3_strobes", rdc + wrc, 0);
    check("err_mem_unchanged", mem[1][16], 32'hCAFEF00D);

    // Reset during the 2nd READ cycle, W=4
    xact(2, 1, 2'd2, 0, 32'h50, 32'h0BADC0DE, rd, e, lat, rdc, wrc, wa, wdt);
    @(negedge CLK);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_size[2] = 2'd2; req_addr[2] = 32'h50;
    @(posedge CLK);
    @(negedge CLK);
    req_valid[2] = 1'b0;
    check("rst_mid_read1", RD[2], 0);
    @(negedge CLK);
    Reset[2] = 1'b1;
    @(negedge CLK);
    check("rst_mid_RD", RD[2], 1); check("rst_mid_WR", WR[2], 1);
    check("rst_mid_ready", req_ready[2], 0);
    Reset[2] = 1'b0;
    vcnt = 0;
    repeat (8) begin
      @(negedge CLK);
      if (resp_valid[2]) vcnt++;
    end
    check("rst_mid_no_resp", vcnt, 0);
    xact(2, 0, 2'd2, 0, 32'h50, 32'h0, rd, e, lat, rdc, wrc, wa, wdt);
    check("rst_after_rdata", rd, 32'h0BADC0DE); check("rst_after_lat", lat, 5);

    // Random requests against the reference memory, W=3
    w = wait_of(1);
    for (int k = 0; k < 16; k++) begin
      wd = $urandom;
      ref_mem[k] = wd;
      xact(1, 1, 2'd2, 0, 32'h100 + 32'(4 * k), wd, rd, e, lat, rdc, wrc, wa, wdt);
    end
    for (int n = 0; n < 1000; n++) begin
      a  = 32'h100 + 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      ee = ref_err(sz, a[1:0]);
      er = (!we && !ee) ? ref_load(ref_mem[a[5:2]], sz, sg, a[1:0]) : 32'd0;
      xact(1, we, sz, sg, a, wd, rd, e, lat, rdc, wrc, wa, wdt);
      check("rnd_err", e, ee);
      check("rnd_rdata", rd, er);
      check("rnd_lat", lat, ee ? 1 : (!we ? w + 1 : (sz == 2'd2 ? 2 : w + 2)));
      check("rnd_wr_cycles", wrc, (we && !ee) ? 1 : 0);
      check("rnd_rd_cycles", rdc, (ee || (we && sz == 2'd2)) ? 0 : w);
      if (we && !ee) begin
        ref_mem[a[5:2]] = ref_store(ref_mem[a[5:2]], sz, a[1:0], wd);
        check("rnd_wdata", wdt, ref_mem[a[5:2]]);
      end
    end

    check("rd_wr_overlap", overlap, 0);
    check("ready_outside_idle", ready_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
